// File: rtl/mult_div_sequencer.sv
// mult_div_sequencer: multi-cycle HI/LO unit for MULT/MULTU/DIV/DIVU.
// It uses a radix-2 shift-add multiplier and a restoring divider, with 32 iterations per op.
// Optional build macro FAST_MULT_EN computes MULT/MULTU in a single cycle.
module mult_div_sequencer (
  input  logic        clk,
  input  logic        resetn,
  input  logic        valid,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        flush,
  output logic        ready,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        is_div_q, is_div_d;
  logic        neg_res_q, neg_res_d;   // negate product / quotient at completion
  logic        neg_rem_q, neg_rem_d;   // negate remainder (dividend sign)
  logic        dz_q, dz_d;             // divide by zero
  logic [31:0] opnd_q, opnd_d;         // multiplicand or divisor magnitude
  logic [63:0] p_q, p_d;               // {acc_hi, multiplier} or {remainder, quotient}
  logic [31:0] hi_q, hi_d, lo_q, lo_d;

  logic        accept, fast_sel, op_signed;
  logic [31:0] a_abs, b_abs;
  logic [32:0] mul_sum, div_shift;
  logic [33:0] div_diff;
  logic [63:0] mul_next, div_next, prod_fix;
  logic [31:0] quo_fix, rem_fix;
`ifdef FAST_MULT_EN
  logic [63:0] ext_a, ext_b, fast_prod;
`endif

  assign op_signed = ~op[0];
  assign a_abs     = (op_signed && a[31]) ? (32'd0 - a) : a;
  assign b_abs     = (op_signed && b[31]) ? (32'd0 - b) : b;
  assign accept    = valid && (state_q != S_RUN) && !flush;

`ifdef FAST_MULT_EN
  // A 64-bit wrap-around product of extended operands yields both signed and unsigned results.
  assign ext_a     = op_signed ? {{32{a[31]}}, a} : {32'd0, a};
  assign ext_b     = op_signed ? {{32{b[31]}}, b} : {32'd0, b};
  assign fast_prod = ext_a * ext_b;
  assign fast_sel  = ~op[1];
`else
  assign fast_sel  = 1'b0;
`endif

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      dz_q      <= 1'b0;
      opnd_q    <= '0;
      p_q       <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      is_div_q  <= is_div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      dz_q      <= dz_d;
      opnd_q    <= opnd_d;
      p_q       <= p_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  // Next-state logic: flush overrides everything, including a same-cycle request.
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: state_d = accept ? (fast_sel ? S_DONE : S_RUN) : S_IDLE;
        S_RUN:          if (cnt_q == 5'd31) state_d = S_DONE;
        default:        state_d = S_IDLE;
      endcase
    end
  end

  // Iteration step, sign fix-up, and operand load on accept.
  always_comb begin
    cnt_d     = cnt_q;
    is_div_d  = is_div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    dz_d      = dz_q;
    opnd_d    = opnd_q;
    p_d       = p_q;
    hi_d      = hi_q;
    lo_d      = lo_q;

    // Shift-add step: add the multiplicand into the upper half when the multiplier LSB is set.
    // Then shift the combined register right by one bit.
    mul_sum   = {1'b0, p_q[63:32]} + (p_q[0] ? {1'b0, opnd_q} : 33'd0);
    mul_next  = {mul_sum, p_q[31:1]};
    // Restoring step: shift the next dividend bit in, then subtract if the result stays non-negative.
    div_shift = {p_q[63:32], p_q[31]};
    div_diff  = {1'b0, div_shift} - {2'b00, opnd_q};
    div_next  = div_diff[33] ? {div_shift[31:0], p_q[30:0], 1'b0}
                             : {div_diff[31:0], p_q[30:0], 1'b1};
    prod_fix  = neg_res_q ? (64'd0 - mul_next) : mul_next;
    quo_fix   = neg_res_q ? (32'd0 - div_next[31:0]) : div_next[31:0];
    rem_fix   = neg_rem_q ? (32'd0 - div_next[63:32]) : div_next[63:32];

    if (!flush) begin
      if (accept) begin
        cnt_d     = '0;
        is_div_d  = op[1];
        neg_res_d = op_signed && (a[31] ^ b[31]);
        neg_rem_d = op_signed && a[31];
        dz_d      = (b == 32'd0);
        opnd_d    = op[1] ? b_abs : a_abs;
        p_d       = {32'd0, op[1] ? a_abs : b_abs};
`ifdef FAST_MULT_EN
        if (fast_sel) begin
          hi_d = fast_prod[63:32];
          lo_d = fast_prod[31:0];
        end
`endif
      end else if (state_q == S_RUN) begin
        cnt_d = cnt_q + 5'd1;
        p_d   = is_div_q ? div_next : mul_next;
        if (cnt_q == 5'd31) begin
          // A zero divisor leaves the dividend in the remainder, so the sign fix restores a.
          if (is_div_q) begin
            hi_d = rem_fix;
            lo_d = dz_q ? '1 : quo_fix;
          end else begin
            hi_d = prod_fix[63:32];
            lo_d = prod_fix[31:0];
          end
        end
      end
    end
  end

  // Output decode: driven from registered state only.
  always_comb begin
    ready = (state_q != S_RUN);
    busy  = (state_q == S_RUN);
    done  = (state_q == S_DONE);
    hi    = hi_q;
    lo    = lo_q;
  end

endmodule
